trig_sweep: RTL

- Sequential sine/cosine angle generator for the hook-swing path. Holds an internal angle register and steps it on a programmable tick, either ping-ponging between two bounds or rotating continuously.
- Looks up sign-magnitude cos/sin for each angle through a 2-stage registered quarter-wave ROM.
- Feeds the hook position/motion logic. Replaces the free-running combinational lookup with a timed, reloadable, pipelined source.

---
 rtl/trig_sweep.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/trig_sweep.sv
// trig_sweep: timed sine/cosine angle source for the hook-swing path.
// An angle register steps on a divided tick (ping-pong between bounds or
// continuous rotation), is reloadable, and each new angle is looked up in a
// 2-stage registered quarter-wave ROM giving sign-magnitude cos/sin x100.
// Optional build macro TRIG_SWEEP_RADIUS_MUL_EN adds radius/dx/dy and a
// third pipeline stage that scales the magnitudes by radius.
//
// dir | meaning
// 1   | angle increasing (always 1 in rotation mode)
// 0   | angle decreasing toward ANGLE_MIN
module trig_sweep #(
  parameter int VAL_W     = 9,
  parameter int STEP      = 5,
  parameter int ANGLE_MIN = 0,
  parameter int ANGLE_MAX = 180,
  parameter int TICK_DIV  = 1000000,
  parameter int MODE      = 0,
  parameter int R_W       = 9
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic                   hold,
  input  logic                   load,
  input  logic [8:0]             load_angle,
`ifdef TRIG_SWEEP_RADIUS_MUL_EN
  input  logic [R_W-1:0]         radius,
  output logic [VAL_W+R_W-1:0]   dx,
  output logic [VAL_W+R_W-1:0]   dy,
`endif
  output logic [8:0]             angle,
  output logic                   dir,
  output logic [VAL_W-1:0]       cos_mag,
  output logic [VAL_W-1:0]       sin_mag,
  output logic                   sign_cos,
  output logic                   sign_sin,
  output logic                   valid
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [8:0] RST_ANGLE = (MODE == 1) ? 9'd0 : 9'(ANGLE_MIN);
  localparam logic [9:0] STEP_V = 10'(STEP);
  localparam logic [9:0] MIN_V  = 10'(ANGLE_MIN);
  localparam logic [9:0] MAX_V  = 10'(ANGLE_MAX);

  if (VAL_W < 7 || R_W < 1 || TICK_DIV < 2 || STEP < 5 || STEP > 90 ||
      (STEP % 5) != 0 || ANGLE_MAX <= ANGLE_MIN || ANGLE_MAX >= 360) begin : g_param_check
    $error("trig_sweep: illegal parameter set");
  end

  // Quarter-wave table, |cos| x100 indexed by angle/5 within 0..90 degrees.
  function automatic logic [6:0] rom(input logic [4:0] i);
    case (i)
      5'd0:  rom = 7'd100;
      5'd1:  rom = 7'd99;
      5'd2:  rom = 7'd98;
      5'd3:  rom = 7'd96;
      5'd4:  rom = 7'd93;
      5'd5:  rom = 7'd90;
      5'd6:  rom = 7'd86;
      5'd7:  rom = 7'd81;
      5'd8:  rom = 7'd76;
      5'd9:  rom = 7'd70;
      5'd10: rom = 7'd64;
      5'd11: rom = 7'd57;
      5'd12: rom = 7'd50;
      5'd13: rom = 7'd42;
      5'd14: rom = 7'd34;
      5'd15: rom = 7'd25;
      5'd16: rom = 7'd17;
      5'd17: rom = 7'd8;
      default: rom = 7'd0;
    endcase
  endfunction

  logic [DIV_W-1:0] div;
  logic             tick;
  logic             upd;
  logic [9:0]       ld_wrap, ld_rnd;
  logic [8:0]       ld_val;
  logic [9:0]       ang_ext, ang_up;
  logic [8:0]       nxt_angle;
  logic             nxt_dir;
  logic [6:0]       idx;
  logic [4:0]       q;
  logic             s1_v, s1_sc, s1_ss;
  logic [4:0]       s1_q;

  assign tick = enable && !hold && (div == DIV_LAST);

  // Tick divider: counts while running, frozen by hold or enable=0.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      div <= '0;
    else if (enable && !hold)
      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
  end

  // Load value: wrap past 360, round down to 5 degrees, clamp in ping-pong mode.
  always_comb begin
    ld_wrap = (load_angle >= 9'd360) ? {1'b0, load_angle} - 10'd360 : {1'b0, load_angle};
    ld_rnd  = ld_wrap - (ld_wrap % 10'd5);
    ld_val  = ld_rnd[8:0];
    if (MODE == 0) begin
      if (ld_rnd < MIN_V)      ld_val = MIN_V[8:0];
      else if (ld_rnd > MAX_V) ld_val = MAX_V[8:0];
    end
  end

  // Next angle/direction for a tick; reversal ticks clamp onto the bound.
  always_comb begin
    ang_ext   = {1'b0, angle};
    ang_up    = ang_ext + STEP_V;
    nxt_dir   = dir;
    nxt_angle = angle;
    if (MODE == 1) begin
      nxt_angle = (ang_up >= 10'd360) ? 9'(ang_up - 10'd360) : ang_up[8:0];
      nxt_dir   = 1'b1;
    end else if (dir) begin
      if (ang_up > MAX_V) begin
        nxt_angle = MAX_V[8:0];
        nxt_dir   = 1'b0;
      end else begin
        nxt_angle = ang_up[8:0];
      end
    end else begin
      if (ang_ext < MIN_V + STEP_V) begin
        nxt_angle = MIN_V[8:0];
        nxt_dir   = 1'b1;
      end else begin
        nxt_angle = 9'(ang_ext - STEP_V);
      end
    end
  end

  // Angle register; load wins over a same-cycle tick. Reset queues a lookup.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      angle <= RST_ANGLE;
      dir   <= 1'b1;
      upd   <= 1'b1;
    end else begin
      upd <= 1'b0;
      if (load) begin
        angle <= ld_val;
        upd   <= 1'b1;
      end else if (tick) begin
        angle <= nxt_angle;
        dir   <= nxt_dir;
        upd   <= 1'b1;
      end
    end
  end

  // Fold angle/5 (0..71) onto the first-quadrant index 0..18.
  always_comb begin
    idx = 7'(angle / 9'd5);
    if (idx <= 7'd18)      q = idx[4:0];
    else if (idx <= 7'd36) q = 5'(7'd36 - idx);
    else if (idx <= 7'd54) q = 5'(idx - 7'd36);
    else                   q = 5'(7'd72 - idx);
  end

  // S1: register quadrant index and signs (zero magnitudes land on sign 1).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_v  <= 1'b0;
      s1_q  <= '0;
      s1_sc <= 1'b1;
      s1_ss <= 1'b1;
    end else begin
      s1_v <= upd;
      if (upd) begin
        s1_q  <= q;
        s1_sc <= (angle <= 9'd90) || (angle >= 9'd270);
        s1_ss <= (angle <= 9'd180);
      end
    end
  end

`ifdef TRIG_SWEEP_RADIUS_MUL_EN
  logic           s2_v;
  logic [R_W-1:0] r_s2;
`endif

  // S2: ROM lookup; cos uses q, sin uses the mirrored index.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cos_mag  <= VAL_W'(100);
      sin_mag  <= '0;
      sign_cos <= 1'b1;
      sign_sin <= 1'b1;
`ifdef TRIG_SWEEP_RADIUS_MUL_EN
      s2_v     <= 1'b0;
      r_s2     <= '0;
`else
      valid    <= 1'b0;
`endif
    end else begin
`ifdef TRIG_SWEEP_RADIUS_MUL_EN
      s2_v  <= s1_v;
`else
      valid <= s1_v;
`endif
      if (s1_v) begin
        cos_mag  <= VAL_W'(rom(s1_q));
        sin_mag  <= VAL_W'(rom(5'd18 - s1_q));
        sign_cos <= s1_sc;
        sign_sin <= s1_ss;
`ifdef TRIG_SWEEP_RADIUS_MUL_EN
        r_s2     <= radius;
`endif
      end
    end
  end

`ifdef TRIG_SWEEP_RADIUS_MUL_EN
  // S3: full-width unsigned scaling by the radius captured at S2.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dx    <= '0;
      dy    <= '0;
      valid <= 1'b0;
    end else begin
      valid <= s2_v;
      if (s2_v) begin
        dx <= (VAL_W+R_W)'(cos_mag) * (VAL_W+R_W)'(r_s2);
        dy <= (VAL_W+R_W)'(sin_mag) * (VAL_W+R_W)'(r_s2);
      end
    end
  end
`endif

endmodule
